// File: rtl/pc_redirect.sv
// pc_redirect: fetch PC owner, EX redirect handling and imem handshake.
// Holds a redirect behind an outstanding fetch and squashes the stale return.
module pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       b_ctrl,
  input  logic             br_valid,
  input  logic [31:0]      br_target,
  input  logic [31:0]      jalr_target,
  input  logic             stall,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  output logic [31:0]      pc_if,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_WAIT,
    S_PEND
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        take;
  logic        accept;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign take   = br_valid && !b_ctrl[1];
  assign target = b_ctrl[0] ? br_target
                            : {jalr_target[31:1], 1'b0};
  assign accept = imem_req && imem_ready;
  assign pc_inc = pc_q + 32'd4;

  assign imem_addr = pc_q;
  assign pc_if     = pc_q;

  // State, PC and pending-target registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Saturating count of taken redirects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_cnt <= '0;
    end else if (take && redirect_cnt != CNT_MAX) begin
      redirect_cnt <= redirect_cnt + CNT_ONE;
    end
  end

  // Next state, next PC, request and flush decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    imem_req   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        imem_req = !stall && !take;
        if (take) begin
          pc_d       = target;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (accept) begin
          pc_d = pc_inc;
        end else if (imem_req) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (take) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          pend_d     = target;
          if (imem_ready) begin
            pc_d    = target;
            state_d = S_RUN;
          end else begin
            state_d = S_PEND;
          end
        end else if (accept) begin
          pc_d    = pc_inc;
          state_d = S_RUN;
        end
      end
      S_PEND: begin
        imem_req = 1'b1;
        if (take) begin
          pend_d     = target;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end
        if (accept) begin
          flush_ifid = 1'b1;
          pc_d       = take ? target : pend_q;
          state_d    = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_redirect.sv
// tb_pc_redirect: directed vectors, expected outputs queued per cycle
// and compared by an independent monitor on the falling edge.
module tb_pc_redirect;

  logic        clk;
  logic        rst;
  logic [1:0]  b_ctrl;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] jalr_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_if;
  logic        flush_ifid;
  logic        flush_idex;
  logic [15:0] redirect_cnt;

  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic        s_fi;
  logic        s_fx;
  logic [1:0]  s_cnt;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        fi;
    logic        fx;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pc_redirect #(.RESET_PC(32'h100), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .b_ctrl(b_ctrl),
    .br_valid(br_valid), .br_target(br_target),
    .jalr_target(jalr_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .pc_if(pc_if),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .redirect_cnt(redirect_cnt)
  );

  pc_redirect #(.RESET_PC(32'h100), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .b_ctrl(b_ctrl),
    .br_valid(br_valid), .br_target(br_target),
    .jalr_target(jalr_target), .stall(stall),
    .imem_req(s_req), .imem_addr(s_addr),
    .imem_ready(imem_ready), .pc_if(s_pc),
    .flush_ifid(s_fi), .flush_idex(s_fx),
    .redirect_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [1:0] sat;
      e = q.pop_front();
      sat = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      chk("imem_req", {31'b0, imem_req}, {31'b0, e.req});
      chk("imem_addr", imem_addr, e.addr);
      chk("pc_if", pc_if, e.addr);
      chk("flush_ifid", {31'b0, flush_ifid}, {31'b0, e.fi});
      chk("flush_idex", {31'b0, flush_idex}, {31'b0, e.fx});
      chk("redirect_cnt", {16'b0, redirect_cnt}, {16'b0, e.cnt});
      chk("sat_cnt", {30'b0, s_cnt}, {30'b0, sat});
    end
  end

  task automatic cyc(
    input logic r, input logic bv, input logic [1:0] bc,
    input logic [31:0] bt, input logic [31:0] jt,
    input logic st, input logic rdy,
    input logic req, input logic [31:0] addr,
    input logic fi, input logic fx, input logic [15:0] cnt);
    exp_t e;
    rst         = r;
    br_valid    = bv;
    b_ctrl      = bc;
    br_target   = bt;
    jalr_target = jt;
    stall       = st;
    imem_ready  = rdy;
    e.req  = req;
    e.addr = addr;
    e.fi   = fi;
    e.fx   = fx;
    e.cnt  = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    br_valid    = 1'b0;
    b_ctrl      = 2'd2;
    br_target   = 32'h0;
    jalr_target = 32'h0;
    stall       = 1'b0;
    imem_ready  = 1'b1;
    @(posedge clk);
    #1;
    // reset held, a take on the inputs must not flush
    cyc(0, 1, 1, 32'h40, 0, 0, 1, 0, 32'h100, 0, 0, 0);
    // boot cycle, then sequential fetch
    cyc(1, 0, 2, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h100, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h104, 0, 0, 0);
    // branch at 0x108 to 0x40
    cyc(1, 1, 1, 32'h40, 0, 0, 1, 0, 32'h108, 1, 1, 0);
    // jalr to 0x2001 -> 0x2000
    cyc(1, 1, 0, 32'h0, 32'h2001, 0, 1, 0, 32'h40, 1, 1, 1);
    // branch to 0x10
    cyc(1, 1, 1, 32'h10, 0, 0, 1, 0, 32'h2000, 1, 1, 2);
    // three not-ready cycles with stall toggling
    cyc(1, 0, 2, 0, 0, 0, 0, 1, 32'h10, 0, 0, 3);
    cyc(1, 0, 2, 0, 0, 1, 0, 1, 32'h10, 0, 0, 3);
    cyc(1, 0, 2, 0, 0, 0, 0, 1, 32'h10, 0, 0, 3);
    cyc(1, 0, 2, 0, 0, 1, 1, 1, 32'h10, 0, 0, 3);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h14, 0, 0, 3);
    // stall in RUN holds pc with no request
    cyc(1, 0, 2, 0, 0, 1, 1, 0, 32'h18, 0, 0, 3);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h18, 0, 0, 3);
    // back to 0x10, redirect to 0x80 while waiting
    cyc(1, 1, 1, 32'h10, 0, 0, 1, 0, 32'h1c, 1, 1, 3);
    cyc(1, 0, 2, 0, 0, 0, 0, 1, 32'h10, 0, 0, 4);
    cyc(1, 1, 1, 32'h80, 0, 0, 0, 1, 32'h10, 1, 1, 4);
    cyc(1, 0, 2, 0, 0, 0, 0, 1, 32'h10, 0, 0, 5);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h10, 1, 0, 5);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h80, 0, 0, 5);
    // take and ready together in WAIT
    cyc(1, 0, 2, 0, 0, 0, 0, 1, 32'h84, 0, 0, 5);
    cyc(1, 1, 1, 32'h200, 0, 0, 1, 1, 32'h84, 1, 1, 5);
    // two takes in PEND, latest wins
    cyc(1, 0, 2, 0, 0, 0, 0, 1, 32'h200, 0, 0, 6);
    cyc(1, 1, 1, 32'h300, 0, 0, 0, 1, 32'h200, 1, 1, 6);
    cyc(1, 1, 1, 32'h400, 0, 1, 0, 1, 32'h200, 1, 1, 7);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h200, 1, 0, 8);
    // wrap from 0xFFFF_FFFC to 0
    cyc(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h400, 1, 1, 8);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 9);
    // b_ctrl=3 and br_valid=0 are both sequential
    cyc(1, 1, 3, 32'h500, 0, 0, 1, 1, 32'h0, 0, 0, 9);
    cyc(1, 0, 1, 32'h123, 0, 0, 1, 1, 32'h4, 0, 0, 9);
    // enter WAIT, then reset mid-request
    cyc(1, 0, 2, 0, 0, 0, 0, 1, 32'h8, 0, 0, 9);
    cyc(0, 1, 1, 32'h600, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h100, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 32'h104, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
